// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared FSM encoding and default counter sizing for the slow-wave path
package period_meter_pkg;
    typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;
    localparam int WIDTH_DEF = 33;
    localparam int TIMEOUT_DEF = 200000000;
endpackage

// File: rtl/period_meter_if.sv
// period_meter_if: slow wave in, measured period/high time and status out
interface period_meter_if import period_meter_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
    logic             sig_in;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             valid;
    logic             stalled;
    modport master (output sig_in, input period, high_time, valid, stalled);
    modport slave  (input sig_in, output period, high_time, valid, stalled);
endinterface

// File: rtl/period_meter_edge_sync.sv
// edge_sync: two-flop synchronizer with history flop, yielding level and single-cycle edges
module edge_sync (
    input  logic in_clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1, s2, s3;
    always_ff @(posedge in_clk)
        if (reset) {s1, s2, s3} <= 3'b000;
        else       {s1, s2, s3} <= {d, s1, s2};
    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;
endmodule

// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow wave in in_clk cycles, with stall timeout
module period_meter import period_meter_pkg::*; #(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic           in_clk,
    input logic           reset,
    period_meter_if.slave bus
);
    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, hcnt, hi_lat;
    logic             level, rise, fall, meas, tmo;
    edge_sync u_sync (.in_clk(in_clk), .reset(reset), .d(bus.sig_in), .level(level), .rise(rise), .fall(fall));
    assign meas = state == MEASURE;
    // a rise in the timeout cycle still counts as a normal measurement
    assign tmo = meas && !rise && cnt == WIDTH'(TIMEOUT);
    always_comb state_n = rise ? MEASURE : tmo ? IDLE : state;
    always_ff @(posedge in_clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            hcnt          <= '0;
            hi_lat        <= '0;
            bus.period    <= '0;
            bus.high_time <= '0;
            bus.valid     <= 1'b0;
            bus.stalled   <= 1'b0;
        end else begin
            state     <= state_n;
            bus.valid <= rise && meas;
            if (rise) begin
                cnt  <= WIDTH'(1);
                hcnt <= WIDTH'(1);
            end else if (meas && !tmo) begin
                cnt <= cnt + 1'b1;
                if (level) hcnt <= hcnt + 1'b1;
            end
            if (meas && fall) hi_lat <= hcnt;
            if (rise && meas) begin
                bus.period    <= cnt;
                bus.high_time <= hi_lat;
                bus.stalled   <= 1'b0;
            end else if (tmo) bus.stalled <= 1'b1;
        end
    end
endmodule
